// File: rtl/operand_fetch.sv
// Register-read stage: drives register file read ports, merges writeback bypass
// data and r15 substitution, then hands both operands to execute on valid/ready.
module operand_fetch #(
    parameter int          CTRL_W    = 16,
    parameter int unsigned PC_OFFSET = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rm,
    input  logic [3:0]        in_rd,
    input  logic [31:0]       in_pc,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [3:0]        rf_read_regA,
    output logic [3:0]        rf_read_regB,
    input  logic [31:0]       rf_data_regA,
    input  logic [31:0]       rf_data_regB,
    input  logic              wb_en,
    input  logic [3:0]        wb_reg,
    input  logic [31:0]       wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_a,
    output logic [31:0]       out_b,
    output logic [3:0]        out_rd,
    output logic [31:0]       out_pc,
    output logic [CTRL_W-1:0] out_ctrl
);

    typedef enum logic [1:0] {IDLE, FETCH, DATA, VALID} state_t;

    state_t            state, state_nxt;
    logic [3:0]        rn, rm, rd;
    logic [31:0]       pc;
    logic [CTRL_W-1:0] ctrl;
    logic              fwd_a, fwd_b;
    logic [31:0]       fwd_data_a, fwd_data_b;
    logic              accept;
    logic              hit_a, hit_b;
    logic [31:0]       opnd_a, opnd_b;

    // Priority: r15 -> live writeback -> writeback seen during FETCH -> register file.
    function automatic logic [31:0] select_operand(
        input logic [3:0]  src,
        input logic [31:0] pc_val,
        input logic        live_hit,
        input logic [31:0] live_data,
        input logic        fwd,
        input logic [31:0] fwd_data,
        input logic [31:0] rf_data
    );
        if (src == 4'd15)
            return pc_val + 32'(PC_OFFSET);
        else if (live_hit)
            return live_data;
        else if (fwd)
            return fwd_data;
        else
            return rf_data;
    endfunction

    assign rf_read_regA = rn;
    assign rf_read_regB = rm;
    assign accept       = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = FETCH;
            FETCH: state_nxt = DATA;
            DATA:  state_nxt = VALID;
            VALID: if (out_ready) state_nxt = in_valid ? FETCH : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Writes to r15 never bypass; the PC substitution always wins there.
    always_comb begin
        in_ready = !reset && ((state == IDLE) || ((state == VALID) && out_ready));
        hit_a    = wb_en && (wb_reg == rn) && (rn != 4'd15);
        hit_b    = wb_en && (wb_reg == rm) && (rm != 4'd15);
        opnd_a   = select_operand(rn, pc, hit_a, wb_data, fwd_a, fwd_data_a, rf_data_regA);
        opnd_b   = select_operand(rm, pc, hit_b, wb_data, fwd_b, fwd_data_b, rf_data_regB);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rn         <= '0;
            rm         <= '0;
            rd         <= '0;
            pc         <= '0;
            ctrl       <= '0;
            fwd_a      <= 1'b0;
            fwd_b      <= 1'b0;
            fwd_data_a <= '0;
            fwd_data_b <= '0;
            out_valid  <= 1'b0;
            out_a      <= '0;
            out_b      <= '0;
            out_rd     <= '0;
            out_pc     <= '0;
            out_ctrl   <= '0;
        end else begin
            if (accept) begin
                rn   <= in_rn;
                rm   <= in_rm;
                rd   <= in_rd;
                pc   <= in_pc;
                ctrl <= in_ctrl;
            end
            // The register file samples its address at the end of FETCH and misses
            // a same-edge write, so that write is held here for DATA.
            if (state == FETCH) begin
                fwd_a      <= hit_a;
                fwd_b      <= hit_b;
                fwd_data_a <= wb_data;
                fwd_data_b <= wb_data;
            end
            if (state == DATA) begin
                out_a     <= opnd_a;
                out_b     <= opnd_b;
                out_rd    <= rd;
                out_pc    <= pc;
                out_ctrl  <= ctrl;
                out_valid <= 1'b1;
            end else if (state == VALID) begin
                if (out_ready)
                    out_valid <= 1'b0;
                if (hit_a)
                    out_a <= wb_data;
                if (hit_b)
                    out_b <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, stall/back-to-back and reset
// sequences, then randomized traffic checked against an architectural register model.
module tb_operand_fetch;

    localparam int CTRL_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_rn, in_rm, in_rd;
    logic [31:0]       in_pc;
    logic [CTRL_W-1:0] in_ctrl;
    logic [3:0]        rf_read_regA, rf_read_regB;
    logic [31:0]       rf_data_regA, rf_data_regB;
    logic              wb_en;
    logic [3:0]        wb_reg;
    logic [31:0]       wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_a, out_b;
    logic [3:0]        out_rd;
    logic [31:0]       out_pc;
    logic [CTRL_W-1:0] out_ctrl;

    operand_fetch #(.CTRL_W(CTRL_W), .PC_OFFSET(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd), .in_pc(in_pc), .in_ctrl(in_ctrl),
        .rf_read_regA(rf_read_regA), .rf_read_regB(rf_read_regB),
        .rf_data_regA(rf_data_regA), .rf_data_regB(rf_data_regB),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_pc(out_pc), .out_ctrl(out_ctrl)
    );

    always #5 clk = ~clk;

    // Architectural register file with registered read data.
    logic [31:0] arch [16];
    always @(posedge clk) begin
        rf_data_regA <= arch[rf_read_regA];
        rf_data_regB <= arch[rf_read_regB];
        if (wb_en) arch[wb_reg] <= wb_data;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] r, input logic [31:0] d);
        wb_en = 1'b1; wb_reg = r; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic send(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                        input logic [31:0] pc, input logic [15:0] ctrl);
        in_valid = 1'b1; in_rn = rn; in_rm = rm; in_rd = rd; in_pc = pc; in_ctrl = ctrl;
    endtask

    typedef struct {
        logic [3:0]  rn, rm, rd;
        logic [31:0] pc;
        logic        f_en;
        logic [3:0]  f_reg;
        logic [31:0] f_data;
        logic        d_en;
        logic [3:0]  d_reg;
        logic [31:0] d_data;
        logic [31:0] exp_a, exp_b;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  e_rn, e_rm, e_rd;
        logic [31:0] e_pc, e_a, e_b;
        logic [15:0] e_ctrl;
        int          cnt;
        bit          ovld, acc, exp_rdy;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_rn = '0; in_rm = '0; in_rd = '0; in_pc = '0; in_ctrl = '0;
        wb_en = 1'b0; wb_reg = '0; wb_data = '0;

        // Clear the register file while the stage is held in reset.
        for (int r = 0; r < 16; r++) wr(4'(r), 32'd0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_b", out_b, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        reset = 1'b0;
        tick();
        chk("idle_in_ready", in_ready, 1);

        wr(4'd3, 32'h11); wr(4'd4, 32'h22); wr(4'd2, 32'h1234); wr(4'd7, 32'h77);

        //         rn     rm     rd     pc            f_en  f_reg  f_data        d_en  d_reg  d_data        exp_a         exp_b
        vecs[0] = '{4'd3,  4'd4,  4'd5,  32'h100,      1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        32'h11,       32'h22};
        vecs[1] = '{4'd15, 4'd15, 4'd1,  32'h200,      1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        32'h208,      32'h208};
        vecs[2] = '{4'd2,  4'd4,  4'd2,  32'h10,       1'b1, 4'd2,  32'hDEAD,     1'b0, 4'd0,  32'h0,        32'hDEAD,     32'h22};
        vecs[3] = '{4'd6,  4'd6,  4'd3,  32'h14,       1'b0, 4'd0,  32'h0,        1'b1, 4'd6,  32'hDEAD,     32'hDEAD,     32'hDEAD};
        vecs[4] = '{4'd2,  4'd3,  4'd4,  32'h18,       1'b1, 4'd2,  32'hAAAA,     1'b1, 4'd2,  32'hBBBB,     32'hBBBB,     32'h11};
        vecs[5] = '{4'd15, 4'd3,  4'd6,  32'hFFFFFFFC, 1'b1, 4'd15, 32'h999,      1'b1, 4'd15, 32'h888,      32'h4,        32'h11};
        vecs[6] = '{4'd4,  4'd8,  4'd7,  32'h20,       1'b1, 4'd8,  32'h5A5A,     1'b0, 4'd0,  32'h0,        32'h22,       32'h5A5A};
        vecs[7] = '{4'd3,  4'd4,  4'd8,  32'h24,       1'b1, 4'd9,  32'h1,        1'b1, 4'd10, 32'h2,        32'h11,       32'h22};

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].rn, vecs[i].rm, vecs[i].rd, vecs[i].pc, 16'(16'h1000 + i));
            chk($sformatf("v%0d_in_ready", i), in_ready, 1);
            tick();
            in_valid = 1'b0;
            wb_en = vecs[i].f_en; wb_reg = vecs[i].f_reg; wb_data = vecs[i].f_data;
            chk($sformatf("v%0d_fetch_valid", i), out_valid, 0);
            tick();
            wb_en = vecs[i].d_en; wb_reg = vecs[i].d_reg; wb_data = vecs[i].d_data;
            chk($sformatf("v%0d_data_valid", i), out_valid, 0);
            tick();
            wb_en = 1'b0;
            chk($sformatf("v%0d_out_valid", i), out_valid, 1);
            chk($sformatf("v%0d_out_a", i), out_a, vecs[i].exp_a);
            chk($sformatf("v%0d_out_b", i), out_b, vecs[i].exp_b);
            chk($sformatf("v%0d_out_rd", i), out_rd, vecs[i].rd);
            chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].pc);
            chk($sformatf("v%0d_out_ctrl", i), out_ctrl, 32'(16'h1000 + i));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("v%0d_drain_valid", i), out_valid, 0);
        end

        // Stall with a writeback to rm landing during the stall, then back-to-back accept.
        send(4'd3, 4'd7, 4'd1, 32'h300, 16'hABCD);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("stall_start_b", out_b, 32'h77);
        for (int s = 0; s < 4; s++) begin
            wb_en = (s == 1); wb_reg = 4'd7; wb_data = 32'h55;
            tick();
            wb_en = 1'b0;
            chk($sformatf("stall%0d_valid", s), out_valid, 1);
            chk($sformatf("stall%0d_a", s), out_a, 32'h11);
            chk($sformatf("stall%0d_b", s), out_b, (s >= 1) ? 32'h55 : 32'h77);
            chk($sformatf("stall%0d_rd", s), out_rd, 1);
            chk($sformatf("stall%0d_pc", s), out_pc, 32'h300);
            chk($sformatf("stall%0d_ctrl", s), out_ctrl, 32'hABCD);
        end
        out_ready = 1'b1;
        send(4'd4, 4'd3, 4'd2, 32'h400, 16'h0042);
        #1;
        chk("b2b_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_drop1", out_valid, 0);
        tick();
        chk("b2b_drop2", out_valid, 0);
        tick();
        chk("b2b_valid", out_valid, 1);
        chk("b2b_a", out_a, 32'h22);
        chk("b2b_b", out_b, 32'h11);
        chk("b2b_pc", out_pc, 32'h400);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset while in DATA discards the instruction.
        send(4'd3, 4'd4, 4'd9, 32'h500, 16'h0007);
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("rstdata_in_ready", in_ready, 0);
        tick();
        chk("rstdata_valid", out_valid, 0);
        chk("rstdata_in_ready2", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("rstdata_idle_ready", in_ready, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rstdata_quiet%0d", k), out_valid, 0);
        end

        // Randomized traffic against an architectural model.
        cnt = 0; ovld = 1'b0;
        e_rn = '0; e_rm = '0; e_rd = '0; e_pc = '0; e_ctrl = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_rn     = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            in_rm     = ($urandom_range(0, 7) == 0) ? in_rn : 4'($urandom_range(0, 15));
            in_rd     = 4'($urandom_range(0, 15));
            in_pc     = $urandom;
            in_ctrl   = 16'($urandom);
            wb_en     = ($urandom_range(0, 1) != 0);
            wb_reg    = 4'($urandom_range(0, 15));
            wb_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_rdy = (cnt == 0) && (!ovld || out_ready);
            chk("rnd_in_ready", in_ready, exp_rdy);
            acc = in_valid && exp_rdy;
            if (acc) begin
                e_rn = in_rn; e_rm = in_rm; e_rd = in_rd; e_pc = in_pc; e_ctrl = in_ctrl;
            end
            tick();
            if (acc) begin
                cnt = 2; ovld = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) ovld = 1'b1;
            end else if (ovld && out_ready) begin
                ovld = 1'b0;
            end
            chk("rnd_out_valid", out_valid, ovld);
            if (ovld) begin
                e_a = (e_rn == 4'd15) ? e_pc + 32'd8 : arch[e_rn];
                e_b = (e_rm == 4'd15) ? e_pc + 32'd8 : arch[e_rm];
                chk("rnd_out_a", out_a, e_a);
                chk("rnd_out_b", out_b, e_b);
                chk("rnd_out_rd", out_rd, e_rd);
                chk("rnd_out_pc", out_pc, e_pc);
                chk("rnd_out_ctrl", out_ctrl, e_ctrl);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
